sdram_capture_writer: RTL and testbench

//  Avalon-MM burst-write initiator driving the HPS f2h_sdram0 responder port. Accepts
//  256-bit capture words on a valid/ready stream, buffers them, writes them to a ring
//  (or one-shot) region of HPS SDRAM in fixed-length bursts. Sits between the capture

---
 rtl/sdram_capture_writer_pkg.sv | 16 +
 rtl/sdram_capture_writer_fifo.sv | 58 +++++
 rtl/sdram_capture_writer.sv | 178 +++++++++++++++++
 tb/tb_sdram_capture_writer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_capture_writer_pkg.sv
// Shared defaults and FSM encodings for the SDRAM capture writer.
package sdram_capture_writer_pkg;

    localparam int DEF_ADDR_W     = 27;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_BURST_W    = 8;
    localparam int DEF_BURST_LEN  = 16;
    localparam int DEF_FIFO_DEPTH = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_BURST = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sdram_capture_writer_fifo.sv
// First-word-fall-through synchronous FIFO: the head word is always visible on
// pop_data, so a pop simply advances to the next word.
module sync_fifo_fwft #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_idx];

    // Storage array is plain RAM; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= push_data;
    end

    // Pointers and occupancy; clear drops every buffered word at once.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_idx <= wr_idx + 1'b1;
            if (do_pop)
                rd_idx <= rd_idx + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_capture_writer.sv
// Avalon-MM burst-write initiator: buffers capture words and writes them into a
// ring or one-shot SDRAM region in bursts that never cross the region end.
module sdram_capture_writer
    import sdram_capture_writer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST_W    = DEF_BURST_W,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_words,
    input  logic                  cfg_ring,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic                  busy,
    output logic                  wrapped,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]         state;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  words_q;
    logic               ring_q;
    logic               region_full;
    logic               stop_seen;
    logic [BURST_W-1:0] beat_cnt;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_clear;

    logic [ADDR_W-1:0]  remaining;
    logic [ADDR_W-1:0]  next_ptr;
    logic [BURST_W-1:0] blen;
    logic [BURST_W-1:0] flush_len;
    logic               arm;
    logic               push;
    logic               pop;
    logic               beat_last;
    logic               ptr_at_end;

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (avm_writedata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign avm_byteenable = '1;
    assign busy           = (state != ST_IDLE) && (state != ST_DONE);

    // Burst sizing, handshakes and end-of-burst pointer arithmetic.
    always_comb begin
        remaining  = words_q - wr_ptr;
        blen       = (remaining < ADDR_W'(BURST_LEN)) ? BURST_W'(remaining)
                                                      : BURST_W'(BURST_LEN);
        flush_len  = (32'(fifo_count) < 32'(blen)) ? BURST_W'(fifo_count) : blen;
        arm        = start && ((state == ST_IDLE) || (state == ST_DONE));
        in_ready   = ((state == ST_ARMED) || (state == ST_BURST)) &&
                     !fifo_full && !region_full && !stop_seen;
        push       = in_valid && in_ready;
        pop        = (state == ST_BURST) && avm_write && !avm_waitrequest;
        beat_last  = pop && (beat_cnt == (avm_burstcount - 1'b1));
        next_ptr   = wr_ptr + ADDR_W'(avm_burstcount);
        ptr_at_end = (next_ptr == words_q);
        fifo_clear = arm || (beat_last && ptr_at_end && !ring_q);
    end

    // Main FSM with burst issue, beat counting and region pointer/status updates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            base_q         <= '0;
            words_q        <= '0;
            ring_q         <= 1'b0;
            region_full    <= 1'b0;
            stop_seen      <= 1'b0;
            beat_cnt       <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            avm_write      <= 1'b0;
            wr_ptr         <= '0;
            wrapped        <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_ARMED;
                        base_q      <= cfg_base;
                        words_q     <= cfg_words;
                        ring_q      <= cfg_ring;
                        wr_ptr      <= '0;
                        wrapped     <= 1'b0;
                        overflow    <= 1'b0;
                        region_full <= 1'b0;
                        stop_seen   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        stop_seen <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (32'(fifo_count) >= 32'(blen)) begin
                        avm_address    <= base_q + wr_ptr;
                        avm_burstcount <= blen;
                        avm_write      <= 1'b1;
                        beat_cnt       <= '0;
                        state          <= ST_BURST;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                    end else begin
                        avm_address    <= base_q + wr_ptr;
                        avm_burstcount <= flush_len;
                        avm_write      <= 1'b1;
                        beat_cnt       <= '0;
                        state          <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (stop)
                        stop_seen <= 1'b1;
                    if (pop)
                        beat_cnt <= beat_cnt + 1'b1;
                    if (beat_last) begin
                        avm_write <= 1'b0;
                        beat_cnt  <= '0;
                        if (ptr_at_end && !ring_q) begin
                            wr_ptr      <= next_ptr;
                            region_full <= 1'b1;
                            overflow    <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            if (ptr_at_end) begin
                                wr_ptr  <= '0;
                                wrapped <= 1'b1;
                            end else begin
                                wr_ptr  <= next_ptr;
                            end
                            state <= (stop_seen || stop) ? ST_FLUSH : ST_ARMED;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Self-checking bench: a negedge monitor keeps a scoreboard of accepted words,
// a burst log and an SDRAM image; scenario tasks check results inline.
module tb_sdram_capture_writer;

    typedef struct {
        logic [26:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic          clk;
    logic          reset_n;
    logic [26:0]   cfg_base;
    logic [26:0]   cfg_words;
    logic          cfg_ring;
    logic          start;
    logic          stop;
    logic [255:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [26:0]   avm_address;
    logic [7:0]    avm_burstcount;
    logic          avm_write;
    logic [255:0]  avm_writedata;
    logic [31:0]   avm_byteenable;
    logic          avm_waitrequest;
    logic [26:0]   wr_ptr;
    logic          busy;
    logic          wrapped;
    logic          overflow;

    int            total = 0;
    int            bad   = 0;
    logic [255:0]  exp_q [$];
    burst_t        burst_log [$];
    logic [255:0]  mem [int];
    int            beat_idx = 0;
    bit            in_burst = 0;
    logic [26:0]   cur_addr;
    logic [7:0]    cur_len;
    int            next_seq = 0;
    bit            stall_rand = 0;
    bit            stall_hold = 0;

    sdram_capture_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_base        (cfg_base),
        .cfg_words       (cfg_words),
        .cfg_ring        (cfg_ring),
        .start           (start),
        .stop            (stop),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .avm_address     (avm_address),
        .avm_burstcount  (avm_burstcount),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .wr_ptr          (wr_ptr),
        .busy            (busy),
        .wrapped         (wrapped),
        .overflow        (overflow)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Responder stall generator, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        avm_waitrequest = stall_hold ? 1'b1 : (stall_rand ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    function automatic logic [255:0] word(int s);
        logic [255:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = (32'(s) * 32'd8 + 32'(k)) ^ 32'hC0DE0000;
        return w;
    endfunction

    function automatic int count_mem_bad(int addr0, int seq0, int n);
        int nb = 0;
        for (int i = 0; i < n; i++)
            if (!mem.exists(addr0 + i) || mem[addr0 + i] !== word(seq0 + i))
                nb++;
        return nb;
    endfunction

    // Monitor: scoreboard push on accept, pop/compare on each written beat
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            beat_idx = 0;
            in_burst = 0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(in_data);
            if (avm_write) begin
                if (!in_burst) begin
                    in_burst = 1;
                    cur_addr = avm_address;
                    cur_len  = avm_burstcount;
                    burst_log.push_back('{addr: avm_address, len: avm_burstcount});
                end else begin
                    total++;
                    if (avm_address !== cur_addr || avm_burstcount !== cur_len) begin
                        bad++;
                        $display("[TB] FAIL burst_stable: addr=%0h len=%0d expected addr=%0h len=%0d",
                                 avm_address, avm_burstcount, cur_addr, cur_len);
                    end
                end
                if (!avm_waitrequest) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL beat_data: beat written with empty scoreboard, data=%0h", avm_writedata);
                    end else begin
                        logic [255:0] w;
                        w = exp_q.pop_front();
                        if (avm_writedata !== w) begin
                            bad++;
                            $display("[TB] FAIL beat_data: got %0h expected %0h", avm_writedata, w);
                        end
                    end
                    mem[int'(cur_addr) + beat_idx] = avm_writedata;
                    beat_idx++;
                    if (beat_idx == int'(cur_len)) begin
                        beat_idx = 0;
                        in_burst = 0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_base   = '0;
        cfg_words  = '0;
        cfg_ring   = 1'b0;
        stall_rand = 0;
        stall_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        burst_log.delete();
        mem.delete();
    endtask

    task automatic start_run(input logic [26:0] base, input logic [26:0] words, input logic ring);
        cfg_base  = base;
        cfg_words = words;
        cfg_ring  = ring;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic feed(input int n, input int budget, output int got);
        bit acc;
        got = 0;
        for (int cyc = 0; cyc < budget && got < n; cyc++) begin
            in_valid = 1'b1;
            in_data  = word(next_seq);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                got++;
                next_seq++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int budget);
        bit ok = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk);
            #1;
            if (burst_log.size() >= n && !in_burst) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL wait_bursts: saw %0d bursts, expected %0d", burst_log.size(), n);
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL wait_done: busy=%0b expected 0 within %0d cycles", busy, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (avm_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_write: got %0b expected 0", avm_write); end
        total++; if (avm_address !== 27'd0) begin bad++; $display("[TB] FAIL rst_addr: got %0h expected 0", avm_address); end
        total++; if (avm_burstcount !== 8'd0) begin bad++; $display("[TB] FAIL rst_len: got %0d expected 0", avm_burstcount); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %0b expected 0", in_ready); end
        total++; if (wr_ptr !== 27'd0) begin bad++; $display("[TB] FAIL rst_ptr: got %0d expected 0", wr_ptr); end
        total++; if (busy !== 1'b0 || wrapped !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_status: busy=%0b wrapped=%0b overflow=%0b expected 000", busy, wrapped, overflow);
        end
        total++; if (avm_byteenable !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL byteenable: got %0h expected ffffffff", avm_byteenable); end
    endtask

    task automatic run_forty(input bit stalls);
        int got;
        int seq0;
        logic [26:0] ea [3] = '{27'h100, 27'h110, 27'h120};
        logic [7:0]  el [3] = '{8'd16, 8'd16, 8'd8};
        do_reset();
        stall_rand = stalls;
        start_run(27'h100, 27'd64, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL arm_busy: got %0b expected 1", busy); end
        seq0 = next_seq;
        feed(40, 400, got);
        total++; if (got !== 40) begin bad++; $display("[TB] FAIL feed40: accepted %0d expected 40", got); end
        wait_bursts(2, 400);
        repeat (5) @(posedge clk);
        #1;
        total++; if (burst_log.size() !== 2) begin bad++; $display("[TB] FAIL held_bursts: got %0d bursts expected 2", burst_log.size()); end
        total++; if (wr_ptr !== 27'd32) begin bad++; $display("[TB] FAIL held_ptr: got %0d expected 32", wr_ptr); end
        total++; if (exp_q.size() !== 8) begin bad++; $display("[TB] FAIL held_words: got %0d expected 8", exp_q.size()); end
        pulse_stop();
        wait_done(400);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= burst_log.size() || burst_log[i].addr !== ea[i] || burst_log[i].len !== el[i]) begin
                bad++;
                $display("[TB] FAIL burst%0d: got addr=%0h len=%0d expected addr=%0h len=%0d", i,
                         (i < burst_log.size()) ? burst_log[i].addr : 27'h0,
                         (i < burst_log.size()) ? burst_log[i].len : 8'h0, ea[i], el[i]);
            end
        end
        total++; if (wr_ptr !== 27'd40) begin bad++; $display("[TB] FAIL stop_ptr: got %0d expected 40", wr_ptr); end
        total++; if (count_mem_bad(32'h100, seq0, 40) !== 0) begin
            bad++; $display("[TB] FAIL mem40: %0d bad words expected 0", count_mem_bad(32'h100, seq0, 40));
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("[TB] FAIL drained40: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_basic_stream();
        run_forty(0);
    endtask

    task automatic test_random_stall();
        run_forty(1);
    endtask

    task automatic test_ring_wrap();
        int got;
        int seq0;
        int ea [7] = '{0, 16, 32, 0, 16, 32, 0};
        int el [7] = '{16, 16, 8, 16, 16, 8, 16};
        do_reset();
        start_run(27'd0, 27'd40, 1'b1);
        seq0 = next_seq;
        feed(96, 400, got);
        total++; if (got !== 96) begin bad++; $display("[TB] FAIL feed96: accepted %0d expected 96", got); end
        wait_bursts(7, 400);
        total++; if (burst_log.size() !== 7) begin bad++; $display("[TB] FAIL ring_nbursts: got %0d expected 7", burst_log.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= burst_log.size() || int'(burst_log[i].addr) != ea[i] || int'(burst_log[i].len) != el[i] ||
                int'(burst_log[i].addr) + int'(burst_log[i].len) > 40) begin
                bad++;
                $display("[TB] FAIL ring_burst%0d: got addr=%0d len=%0d expected addr=%0d len=%0d", i,
                         (i < burst_log.size()) ? int'(burst_log[i].addr) : -1,
                         (i < burst_log.size()) ? int'(burst_log[i].len) : -1, ea[i], el[i]);
            end
        end
        total++; if (wrapped !== 1'b1) begin bad++; $display("[TB] FAIL ring_wrapped: got %0b expected 1", wrapped); end
        total++; if (wr_ptr !== 27'd16) begin bad++; $display("[TB] FAIL ring_ptr: got %0d expected 16", wr_ptr); end
        total++; if (count_mem_bad(0, seq0 + 80, 16) !== 0 || count_mem_bad(16, seq0 + 56, 24) !== 0) begin
            bad++; $display("[TB] FAIL ring_mem: latest-lap contents differ, bad=%0d", count_mem_bad(0, seq0 + 80, 16));
        end
    endtask

    task automatic test_one_shot();
        int got;
        int seq0;
        do_reset();
        start_run(27'h200, 27'd20, 1'b0);
        seq0 = next_seq;
        feed(30, 100, got);
        total++; if (got !== 30) begin bad++; $display("[TB] FAIL feed30: accepted %0d expected 30", got); end
        wait_done(200);
        total++; if (burst_log.size() !== 2 || burst_log[0].addr !== 27'h200 || burst_log[0].len !== 8'd16 ||
                     burst_log[1].addr !== 27'h210 || burst_log[1].len !== 8'd4) begin
            bad++; $display("[TB] FAIL oneshot_bursts: got %0d bursts expected (200,16),(210,4)", burst_log.size());
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_ovf: got %0b expected 1", overflow); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_ready: got %0b expected 0", in_ready); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_wrap: got %0b expected 0", wrapped); end
        total++; if (count_mem_bad(32'h200, seq0, 20) !== 0) begin bad++; $display("[TB] FAIL oneshot_mem: %0d bad words", count_mem_bad(32'h200, seq0, 20)); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (avm_write !== 1'b0 || burst_log.size() !== 2) begin
            bad++; $display("[TB] FAIL oneshot_quiet: write=%0b bursts=%0d expected 0 and 2", avm_write, burst_log.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int got;
        int seq0;
        bit hit = 0;
        do_reset();
        start_run(27'h300, 27'd64, 1'b1);
        feed(20, 100, got);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            #1;
            if (in_burst && beat_idx == 7) begin
                hit = 1;
                break;
            end
        end
        total++; if (!hit) begin bad++; $display("[TB] FAIL beat7: beat index %0d never reached 7", beat_idx); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (avm_write !== 1'b0 || avm_address !== 27'd0 || avm_burstcount !== 8'd0) begin
            bad++; $display("[TB] FAIL midrst_avm: write=%0b addr=%0h len=%0d expected 0 0 0", avm_write, avm_address, avm_burstcount);
        end
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || wr_ptr !== 27'd0) begin
            bad++; $display("[TB] FAIL midrst_state: busy=%0b ready=%0b ptr=%0d expected 0 0 0", busy, in_ready, wr_ptr);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        burst_log.delete();
        mem.delete();
        start_run(27'h300, 27'd64, 1'b1);
        total++; if (wr_ptr !== 27'd0 || busy !== 1'b1) begin
            bad++; $display("[TB] FAIL rearm: ptr=%0d busy=%0b expected 0 1", wr_ptr, busy);
        end
        seq0 = next_seq;
        feed(16, 100, got);
        wait_bursts(1, 100);
        total++; if (burst_log.size() !== 1 || burst_log[0].addr !== 27'h300 || burst_log[0].len !== 8'd16) begin
            bad++; $display("[TB] FAIL rearm_burst: got %0d bursts expected one at 300 len 16", burst_log.size());
        end
        total++; if (count_mem_bad(32'h300, seq0, 16) !== 0 || wr_ptr !== 27'd16) begin
            bad++; $display("[TB] FAIL rearm_mem: bad=%0d ptr=%0d expected 0 16", count_mem_bad(32'h300, seq0, 16), wr_ptr);
        end
    endtask

    task automatic test_back_pressure();
        int got;
        int seq0;
        do_reset();
        start_run(27'd0, 27'd256, 1'b1);
        stall_hold = 1;
        repeat (2) @(posedge clk);
        #1;
        seq0 = next_seq;
        feed(100, 200, got);
        total++; if (got !== 64) begin bad++; $display("[TB] FAIL bp_fill: accepted %0d expected 64", got); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready: got %0b expected 0", in_ready); end
        total++; if (exp_q.size() !== 64 || burst_log.size() !== 1) begin
            bad++; $display("[TB] FAIL bp_pending: words=%0d bursts=%0d expected 64 1", exp_q.size(), burst_log.size());
        end
        stall_hold = 0;
        feed(36, 300, got);
        total++; if (got !== 36) begin bad++; $display("[TB] FAIL bp_rest: accepted %0d expected 36", got); end
        wait_bursts(6, 400);
        total++; if (wr_ptr !== 27'd96) begin bad++; $display("[TB] FAIL bp_ptr96: got %0d expected 96", wr_ptr); end
        pulse_stop();
        wait_done(200);
        total++; if (burst_log.size() !== 7 || burst_log[6].addr !== 27'd96 || burst_log[6].len !== 8'd4) begin
            bad++; $display("[TB] FAIL bp_flush: got %0d bursts expected 7 ending (96,4)", burst_log.size());
        end
        total++; if (wr_ptr !== 27'd100 || count_mem_bad(0, seq0, 100) !== 0 || exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL bp_mem: ptr=%0d bad=%0d left=%0d expected 100 0 0",
                            wr_ptr, count_mem_bad(0, seq0, 100), exp_q.size());
        end
    endtask

    // Scenario sequence
    initial begin
        avm_waitrequest = 1'b0;
        test_reset();
        test_basic_stream();
        test_random_stall();
        test_ring_wrap();
        test_one_shot();
        test_reset_mid_burst();
        test_back_pressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
